// File: rtl/hdlc_pkg.sv
// Shared state type and constants for the HDLC receive path.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAG  = 3'd1,
    RECV  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam int         FCS_BYTES = 2;

endpackage

// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive frame controller: sequences one frame, qualifies it and holds its status.
// Optional error counter output Rx_ErrCount is built when HDLC_RX_ERRCNT_EN is defined.
module hdlc_rx_ctrl
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter int MIN_BYTES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx_FlagDetect,
  input  logic       Rx_AbortDetect,
  input  logic       Rx_NewByte,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_FCSen,
  input  logic       Rx_FCSerr,
  input  logic       Rx_Drop,
  output logic       Rx_WrBuff,
  output logic       Rx_StartFCS,
  output logic       Rx_StopFCS,
  output logic       Rx_ValidFrame,
  output logic       Rx_Ready,
  output logic       Rx_EoF,
  output logic [7:0] Rx_FrameSize,
  output logic       Rx_Overflow,
  output logic       Rx_AbortSignal,
  output logic       Rx_FrameError
`ifdef HDLC_RX_ERRCNT_EN
  ,
  output logic [7:0] Rx_ErrCount
`endif
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);
  localparam logic [7:0] MIN_CNT = 8'(MIN_BYTES);
  localparam logic [7:0] FCS_CNT = 8'(FCS_BYTES);

  rx_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] size_q, size_d;
  logic       wr_q, wr_d, start_q, start_d, stop_q, stop_d;
  logic       valid_q, valid_d, eof_q, eof_d, ready_q, ready_d;
  logic       ovf_q, ovf_d, abort_q, abort_d, ferr_q, ferr_d;
  logic       err_evt_s;
  logic       fcs_bad_s;

  // The data byte goes straight to the buffer; the controller only strobes it.
  logic unused_data_s;
  assign unused_data_s = ^Rx_Data;

  assign fcs_bad_s = Rx_FCSen & Rx_FCSerr;

  // Next-state and registered-output decode; priority is RxEN, abort, flag, byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    wr_d      = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    eof_d     = 1'b0;
    ready_d   = ready_q;
    ovf_d     = ovf_q;
    abort_d   = abort_q;
    ferr_d    = ferr_q;
    err_evt_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (RxEN && Rx_FlagDetect) state_d = FLAG;
        else                       state_d = IDLE;
      end
      FLAG: begin
        if (!RxEN || Rx_AbortDetect) begin
          state_d = IDLE;
        end else if (Rx_FlagDetect) begin
          state_d = FLAG;
        end else if (Rx_NewByte) begin
          state_d = RECV;
          wr_d    = 1'b1;
          start_d = 1'b1;
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          abort_d = 1'b0;
          ferr_d  = 1'b0;
        end else begin
          state_d = FLAG;
        end
      end
      RECV: begin
        if (!RxEN) begin
          state_d = IDLE;
        end else if (Rx_AbortDetect) begin
          state_d   = IDLE;
          abort_d   = 1'b1;
          eof_d     = 1'b1;
          err_evt_s = 1'b1;
        end else if (Rx_FlagDetect) begin
          if (cnt_q < MIN_CNT) begin
            state_d   = FLAG;
            ferr_d    = 1'b1;
            eof_d     = 1'b1;
            err_evt_s = 1'b1;
          end else begin
            state_d = CHECK;
            stop_d  = 1'b1;
          end
        end else if (Rx_NewByte) begin
          // Once the buffer is full, further bytes are dropped and only flagged.
          if (cnt_q < MAX_CNT) begin
            wr_d  = 1'b1;
            cnt_d = cnt_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = RECV;
        end
      end
      CHECK: begin
        if (!RxEN) begin
          state_d = IDLE;
        end else if (fcs_bad_s || ovf_q) begin
          state_d   = FLAG;
          ferr_d    = ferr_q | fcs_bad_s;
          eof_d     = 1'b1;
          err_evt_s = 1'b1;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
          eof_d   = 1'b1;
          if (Rx_FCSen) size_d = cnt_q - FCS_CNT;
          else          size_d = cnt_q;
        end
      end
      DONE: begin
        if (Rx_Drop) begin
          state_d = IDLE;
          ready_d = 1'b0;
          size_d  = 8'd0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == RECV);
  end

  // State, counter and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      size_q  <= 8'd0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef HDLC_RX_ERRCNT_EN
  logic [7:0] errcnt_q;

  // Saturating count of frames that ended in error.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      errcnt_q <= 8'd0;
    end else if (err_evt_s && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end else begin
      errcnt_q <= errcnt_q;
    end
  end

  assign Rx_ErrCount = errcnt_q;
`else
  logic unused_err_s;
  assign unused_err_s = err_evt_s;
`endif

  assign Rx_WrBuff      = wr_q;
  assign Rx_StartFCS    = start_q;
  assign Rx_StopFCS     = stop_q;
  assign Rx_ValidFrame  = valid_q;
  assign Rx_Ready       = ready_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_AbortSignal = abort_q;
  assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Self-checking bench for hdlc_rx_ctrl: directed and random frames against a frame-level model.
// Also checks Rx_ErrCount when built with HDLC_RX_ERRCNT_EN.
module tb_hdlc_rx_ctrl;

  localparam int MAXB = 128;
  localparam int MINB = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       RxEN = 1'b0;
  logic       Rx_FlagDetect = 1'b0;
  logic       Rx_AbortDetect = 1'b0;
  logic       Rx_NewByte = 1'b0;
  logic [7:0] Rx_Data = 8'd0;
  logic       Rx_FCSen = 1'b0;
  logic       Rx_FCSerr = 1'b0;
  logic       Rx_Drop = 1'b0;
  logic       Rx_WrBuff, Rx_StartFCS, Rx_StopFCS, Rx_ValidFrame, Rx_Ready, Rx_EoF;
  logic [7:0] Rx_FrameSize;
  logic       Rx_Overflow, Rx_AbortSignal, Rx_FrameError;
`ifdef HDLC_RX_ERRCNT_EN
  logic [7:0] Rx_ErrCount;
  int         exp_errs = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int c_wr = 0, c_start = 0, c_start_wr = 0, c_stop = 0, c_eof = 0;

  hdlc_rx_ctrl #(.MAX_BYTES(MAXB), .MIN_BYTES(MINB)) dut (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
    .Rx_FCSen(Rx_FCSen), .Rx_FCSerr(Rx_FCSerr), .Rx_Drop(Rx_Drop),
    .Rx_WrBuff(Rx_WrBuff), .Rx_StartFCS(Rx_StartFCS), .Rx_StopFCS(Rx_StopFCS),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_Ready(Rx_Ready), .Rx_EoF(Rx_EoF),
    .Rx_FrameSize(Rx_FrameSize), .Rx_Overflow(Rx_Overflow),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_FrameError(Rx_FrameError)
`ifdef HDLC_RX_ERRCNT_EN
    , .Rx_ErrCount(Rx_ErrCount)
`endif
  );

  always #5 Clk = ~Clk;

  // Pulse tally, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Rx_WrBuff)                c_wr++;
    if (Rx_StartFCS)              c_start++;
    if (Rx_StartFCS && Rx_WrBuff) c_start_wr++;
    if (Rx_StopFCS)               c_stop++;
    if (Rx_EoF)                   c_eof++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_counts();
    c_wr = 0; c_start = 0; c_start_wr = 0; c_stop = 0; c_eof = 0;
  endtask

  task automatic send_byte();
    Rx_NewByte = 1'b1;
    Rx_Data    = 8'($urandom);
    tick();
    Rx_NewByte = 1'b0;
  endtask

  task automatic drive_frame(input int n, input bit abort);
    Rx_FlagDetect = 1'b1;
    tick();
    Rx_FlagDetect = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte();
    end
    repeat ($urandom_range(0, 2)) tick();
    if (abort) Rx_AbortDetect = 1'b1;
    else       Rx_FlagDetect  = 1'b1;
    tick();
    Rx_AbortDetect = 1'b0;
    Rx_FlagDetect  = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drop_frame(input string tag);
    Rx_Drop = 1'b1;
    tick();
    Rx_Drop = 1'b0;
    chk({tag, "_drop_ready"}, 32'(Rx_Ready), 32'd0);
    chk({tag, "_drop_size"}, 32'(Rx_FrameSize), 32'd0);
  endtask

  // Send one frame of n bytes and compare the outcome with the frame-level rules.
  task automatic run_frame(input string tag, input int n, input bit abort,
                           input bit fcsen, input bit fcserr, input bit keep);
    int e_wr, e_size;
    bit e_ovf, e_short, e_fcs, e_ready;
    Rx_FCSen  = fcsen;
    Rx_FCSerr = fcserr;
    clr_counts();
    drive_frame(n, abort);
    e_wr    = (n < MAXB) ? n : MAXB;
    e_ovf   = (n > MAXB);
    e_short = !abort && (n < MINB);
    e_fcs   = !abort && !e_short && fcsen && fcserr;
    e_ready = !abort && !e_short && !e_fcs && !e_ovf;
    e_size  = e_ready ? (fcsen ? n - 2 : n) : 0;
    chk({tag, "_writes"}, 32'(c_wr), 32'(e_wr));
    chk({tag, "_startfcs"}, 32'(c_start), 32'd1);
    chk({tag, "_start_with_wr"}, 32'(c_start_wr), 32'd1);
    chk({tag, "_stopfcs"}, 32'(c_stop), (!abort && !e_short) ? 32'd1 : 32'd0);
    chk({tag, "_eof"}, 32'(c_eof), 32'd1);
    chk({tag, "_ready"}, 32'(Rx_Ready), 32'(e_ready));
    chk({tag, "_size"}, 32'(Rx_FrameSize), 32'(e_size));
    chk({tag, "_overflow"}, 32'(Rx_Overflow), 32'(e_ovf));
    chk({tag, "_abort"}, 32'(Rx_AbortSignal), 32'(abort));
    chk({tag, "_frameerr"}, 32'(Rx_FrameError), 32'(e_short || e_fcs));
    chk({tag, "_valid"}, 32'(Rx_ValidFrame), 32'd0);
`ifdef HDLC_RX_ERRCNT_EN
    if (abort || e_short || e_fcs || e_ovf) exp_errs++;
    chk({tag, "_errcnt"}, 32'(Rx_ErrCount), 32'(exp_errs > 255 ? 255 : exp_errs));
`endif
    if (e_ready && !keep) drop_frame(tag);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_pulses", {29'd0, Rx_WrBuff, Rx_StartFCS, Rx_StopFCS}, 32'd0);
    chk("rst_status", {28'd0, Rx_ValidFrame, Rx_Ready, Rx_EoF, Rx_Overflow}, 32'd0);
    chk("rst_flags", {30'd0, Rx_AbortSignal, Rx_FrameError}, 32'd0);
    chk("rst_size", 32'(Rx_FrameSize), 32'd0);
    Rst = 1'b1;
    RxEN = 1'b1;
    tick();

    run_frame("good6", 6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("fcserr6", 6, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame("abort3", 3, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("after_abort", 5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("ovf130", 130, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("max128", 128, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("short2", 2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("min4", 4, 1'b0, 1'b0, 1'b0, 1'b1);

    // A held frame blocks the line until dropped.
    clr_counts();
    drive_frame(5, 1'b0);
    chk("held_writes", 32'(c_wr), 32'd0);
    chk("held_eof", 32'(c_eof), 32'd0);
    chk("held_ready", 32'(Rx_Ready), 32'd1);
    chk("held_size", 32'(Rx_FrameSize), 32'd4);
    drop_frame("held");

    // Disabling the receiver mid-frame abandons it silently.
    clr_counts();
    Rx_FlagDetect = 1'b1;
    tick();
    Rx_FlagDetect = 1'b0;
    repeat (3) send_byte();
    chk("rxen_valid_on", 32'(Rx_ValidFrame), 32'd1);
    RxEN = 1'b0;
    repeat (3) tick();
    chk("rxen_valid_off", 32'(Rx_ValidFrame), 32'd0);
    chk("rxen_eof", 32'(c_eof), 32'd0);
    chk("rxen_writes", 32'(c_wr), 32'd3);
    RxEN = 1'b1;
    tick();

    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 4) == 0) n = $urandom_range(125, 132);
      else                           n = $urandom_range(1, 12);
      run_frame($sformatf("rnd%0d", k), n, ($urandom_range(0, 5) == 0),
                1'($urandom), 1'($urandom), 1'b0);
    end

    // Asynchronous reset in the middle of a frame.
    Rx_FlagDetect = 1'b1;
    tick();
    Rx_FlagDetect = 1'b0;
    repeat (2) send_byte();
    Rx_NewByte = 1'b1;
    tick();
    Rx_NewByte = 1'b0;
    chk("pre_rst_valid", 32'(Rx_ValidFrame), 32'd1);
    chk("pre_rst_wr", 32'(Rx_WrBuff), 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("mid_rst_outs", {22'd0, Rx_WrBuff, Rx_StartFCS, Rx_StopFCS, Rx_ValidFrame,
                         Rx_Ready, Rx_EoF, Rx_Overflow, Rx_AbortSignal, Rx_FrameError, 1'b0}, 32'd0);
    chk("mid_rst_size", 32'(Rx_FrameSize), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
